// File: rtl/unsigned_fixed_point_subtractor.sv
// -----------------------------------------------------------------------------
// unsigned_fixed_point_subtractor
//
// Purpose:
//   Streaming unsigned fixed-point subtractor, diff = a - b, in XX.YY format.
//   Both operands use the same format, so the binary points are already aligned
//   and no rescaling or rounding is needed. The datapath is a two-stage
//   pipeline:
//   - S1 holds the operands.
//   - S2 holds the result.
//   Each result is flagged with a borrow bit (a < b). A saturating counter
//   tracks how many delivered results carried a borrow.
//
// Build option:
//   FXSUB_SATURATE_EN  When defined, diff is clamped to 0 whenever borrow=1.
//                      When undefined, diff is the modulo-2^W wrapped value.
//                      The borrow flag, the counter, the latency and the
//                      handshakes are the same in both builds.
//
// Ports (W = INT_BITS + FRAC_BITS):
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous, active-high reset
//   in_valid       in   1      operand pair valid
//   in_ready       out  1      block accepts operands this cycle
//   a              in   W      minuend, unsigned XX.YY
//   b              in   W      subtrahend, unsigned XX.YY
//   out_valid      out  1      result valid
//   out_ready      in   1      downstream accepts result
//   diff           out  W      result, unsigned XX.YY
//   borrow         out  1      1 = a < b for this result
//   underflow_cnt  out  CNT_W  delivered results with borrow=1 (saturating)
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer holds valid and its data stable until that transfer occurs.
//   in_ready is combinational from the pipeline state and out_ready. It never
//   depends on in_valid.
// -----------------------------------------------------------------------------
module unsigned_fixed_point_subtractor #(
  parameter int INT_BITS  = 2,
  parameter int FRAC_BITS = 2,
  parameter int CNT_W     = 8,
  localparam int W        = INT_BITS + FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     diff,
  output logic             borrow,
  output logic [CNT_W-1:0] underflow_cnt
);

  // Stage 1: operand registers
  logic             r_s1_valid;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;

  // Stage 2: result registers
  logic             r_s2_valid;
  logic [W-1:0]     r_diff;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_out_xfer;
  logic [W:0]       w_t;
  logic             w_borrow;
  logic [W-1:0]     w_raw;
  logic [W-1:0]     w_diff;

  // S2 takes a new result when S1 has one and S2 is empty or draining this
  // cycle. S1 can take new operands when it is empty or is moving into S2.
  assign w_adv2     = r_s1_valid && (!r_s2_valid || out_ready);
  assign w_adv1     = !r_s1_valid || w_adv2;
  assign w_out_xfer = r_s2_valid && out_ready;

  // One extra bit on the subtraction: the top bit is the borrow, and the
  // low W bits are the modulo-2^W difference.
  assign w_t      = {1'b0, r_a} - {1'b0, r_b};
  assign w_borrow = w_t[W];
  assign w_raw    = w_t[W-1:0];

`ifdef FXSUB_SATURATE_EN
  assign w_diff = w_borrow ? '0 : w_raw;
`else
  assign w_diff = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a <= a;
        r_b <= b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= 1'b1;
      r_diff     <= w_diff;
      r_borrow   <= w_borrow;
    end else if (w_out_xfer) begin
      // Result left and nothing followed it: S2 empties.
      r_s2_valid <= 1'b0;
    end
  end

  // Counts delivered borrow results. The counter sticks at all-ones and
  // never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_borrow && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready      = w_adv1;
  assign out_valid     = r_s2_valid;
  assign diff          = r_diff;
  assign borrow        = r_borrow;
  assign underflow_cnt = r_cnt;

endmodule
